// File: rtl/controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : controller_pkg
// Purpose  : Shared constants for the debounced controller input processor.
//            Gives the bit index of each direction and button line, the
//            position of the "center" bit in the one-hot direction vector,
//            and the default debounce window.
// Revision : 1.0 - initial release
// ============================================================================
package controller_pkg;

  // Direction line indices. Index 0 has the highest priority.
  localparam int DIR_LEFT   = 0;
  localparam int DIR_RIGHT  = 1;
  localparam int DIR_UP     = 2;
  localparam int DIR_DOWN   = 3;

  // Bit 0 of the one-hot direction vector means "no direction held".
  localparam int CENTER_BIT = 0;

  // Button line indices.
  localparam int BTN_ATTACK = 0;
  localparam int BTN_SHIELD = 1;

  // Debounce window: about 10 ms at a 100 MHz clock.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage : controller_pkg
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module   : debounce_filter
// Purpose  : Synchronises and debounces one raw asynchronous input bit.
//            The bit passes through a SYNC_STAGES-deep flop chain. A change
//            is accepted only after the synchronised value has differed from
//            the accepted value for DEBOUNCE_CYCLES consecutive cycles.
// Ports    : clk    - system clock
//            reset  - asynchronous active-high reset
//            raw    - raw input bit, asynchronous to clk
//            stable - accepted (debounced) value
// Revision : 1.0 - initial release
// ============================================================================
module debounce_filter
  import controller_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL       = 1'b0,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Synchroniser chain. It resets to the inactive level so that no false
  // edge is seen when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Any return to the accepted value restarts the count. The change is
  // accepted only on the DEBOUNCE_CYCLES-th consecutive differing cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_stable <= RESET_VAL;
    end else if (w_sync == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt    <= '0;
      r_stable <= w_sync;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign stable = r_stable;

endmodule : debounce_filter
`default_nettype wire

// File: rtl/controller_debounced.sv
`default_nettype none
// ============================================================================
// Module   : controller_debounced
// Purpose  : Controller input processor. Debounces every raw controller line,
//            priority-encodes the active-low direction lines into a one-hot
//            vector with a center bit, and produces button levels and
//            one-cycle press pulses. led_outputs is the board status word.
// Ports    : clk         - system clock
//            reset       - asynchronous active-high reset
//            dir_l       - raw direction lines, active low
//            btn         - raw button lines, active high
//            dir_onehot  - one-hot direction (bit 0 = center, bit i+1 = dir i)
//            btn_level   - debounced button levels
//            btn_press   - one-cycle pulse on each debounced button press
//            led_outputs - {btn_level, dir_onehot}
// Revision : 1.0 - initial release
// ============================================================================
module controller_debounced
  import controller_pkg::*;
#(
  parameter int NUM_DIRS        = 4,
  parameter int NUM_BTNS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_DIRS-1:0]          dir_l,
  input  logic [NUM_BTNS-1:0]          btn,
  output logic [NUM_DIRS:0]            dir_onehot,
  output logic [NUM_BTNS-1:0]          btn_level,
  output logic [NUM_BTNS-1:0]          btn_press,
  output logic [NUM_DIRS+NUM_BTNS:0]   led_outputs
);

  localparam logic [NUM_DIRS:0] c_DIR_IDLE = (NUM_DIRS + 1)'(1) << CENTER_BIT;

  logic [NUM_DIRS-1:0] w_dir_stable;
  logic [NUM_BTNS-1:0] w_btn_stable;
  logic [NUM_DIRS:0]   w_dir_next;

  logic [NUM_DIRS:0]   r_dir_onehot;
  logic [NUM_BTNS-1:0] r_btn_level;
  logic [NUM_BTNS-1:0] r_btn_press;

  // Direction lines idle high, so their filters reset to 1.
  generate
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_dir
      debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b1),
        .CNT_W           (CNT_W)
      ) u_filt (
        .clk    (clk),
        .reset  (reset),
        .raw    (dir_l[gi]),
        .stable (w_dir_stable[gi])
      );
    end : g_dir

    for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (1'b0),
        .CNT_W           (CNT_W)
      ) u_filt (
        .clk    (clk),
        .reset  (reset),
        .raw    (btn[gi]),
        .stable (w_btn_stable[gi])
      );
    end : g_btn
  endgenerate

  // Priority encoder: scanning from the highest index down lets the lowest
  // active index overwrite everything else, so exactly one bit is ever set.
  always_comb begin
    w_dir_next = c_DIR_IDLE;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (!w_dir_stable[i]) begin
        w_dir_next        = '0;
        w_dir_next[i + 1] = 1'b1;
      end
    end
  end

  // The press pulse is registered alongside the level. It is taken from the
  // new stable value and the level register's previous contents, so it lines
  // up with the first cycle btn_level reads 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dir_onehot <= c_DIR_IDLE;
      r_btn_level  <= '0;
      r_btn_press  <= '0;
    end else begin
      r_dir_onehot <= w_dir_next;
      r_btn_level  <= w_btn_stable;
      r_btn_press  <= w_btn_stable & ~r_btn_level;
    end
  end

  assign dir_onehot  = r_dir_onehot;
  assign btn_level   = r_btn_level;
  assign btn_press   = r_btn_press;
  assign led_outputs = {r_btn_level, r_dir_onehot};

endmodule : controller_debounced
`default_nettype wire

// File: tb/tb_controller_debounced.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_debounced
// Purpose  : Self-checking bench for controller_debounced. Instance u_dut
//            uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4; instance u_dut2 uses
//            SYNC_STAGES=3, DEBOUNCE_CYCLES=1 and is driven with random
//            stimulus against a latency-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_debounced;
  import controller_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dir_l  = 4'hF;
  logic [1:0] btn    = 2'b00;
  logic [3:0] dir2_l = 4'hF;
  logic [1:0] btn2   = 2'b00;

  logic [4:0] dir_onehot, dir2_onehot;
  logic [1:0] btn_level,  btn2_level;
  logic [1:0] btn_press,  btn2_press;
  logic [6:0] led,        led2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] dir;
    logic [1:0] lvl;
    logic [1:0] prs;
  } exp_t;

  typedef struct {
    logic [3:0] dir_l;
    logic [1:0] btn;
    logic [4:0] exp_dir;
    logic [1:0] exp_lvl;
  } vec_t;

  exp_t sb[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  controller_debounced #(
    .NUM_DIRS(4), .NUM_BTNS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk(clk), .reset(reset), .dir_l(dir_l), .btn(btn),
    .dir_onehot(dir_onehot), .btn_level(btn_level),
    .btn_press(btn_press), .led_outputs(led)
  );

  controller_debounced #(
    .NUM_DIRS(4), .NUM_BTNS(2), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .dir_l(dir2_l), .btn(btn2),
    .dir_onehot(dir2_onehot), .btn_level(btn2_level),
    .btn_press(btn2_press), .led_outputs(led2)
  );

  // Reference priority encoder: lowest-index low line wins, else center.
  function automatic logic [4:0] encode(input logic [3:0] d);
    logic [4:0] r;
    r = 5'b00001;
    for (int i = 3; i >= 0; i--) begin
      if (!d[i]) r = 5'b00001 << (i + 1);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_outs(input string name,
                          input logic [4:0] d, input logic [1:0] l,
                          input logic [1:0] p, input logic [6:0] o,
                          input exp_t e);
    chk({name, ".dir"}, 32'(d), 32'(e.dir));
    chk({name, ".lvl"}, 32'(l), 32'(e.lvl));
    chk({name, ".prs"}, 32'(p), 32'(e.prs));
    chk({name, ".led"}, 32'(o), 32'({e.lvl, e.dir}));
    chk({name, ".onehot"}, 32'($onehot(d)), 32'd1);
  endtask

  task automatic chk1(input string name, input logic [4:0] ed,
                      input logic [1:0] el, input logic [1:0] ep);
    exp_t e;
    e.dir = ed; e.lvl = el; e.prs = ep;
    chk_outs(name, dir_onehot, btn_level, btn_press, led, e);
  endtask

  task automatic settle(input int n);
    dir_l = 4'hF;
    btn   = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;
    logic [1:0] prev_lvl;

    vecs[0] = '{4'b1111, 2'b00, 5'b00001, 2'b00};
    vecs[1] = '{4'b1110, 2'b00, 5'b00010, 2'b00};
    vecs[2] = '{4'b0110, 2'b00, 5'b00010, 2'b00};  // left + down: left wins
    vecs[3] = '{4'b0111, 2'b00, 5'b10000, 2'b00};  // release left only
    vecs[4] = '{4'b1101, 2'b00, 5'b00100, 2'b00};
    vecs[5] = '{4'b1011, 2'b11, 5'b01000, 2'b11};  // up + both buttons
    vecs[6] = '{4'b0000, 2'b01, 5'b00010, 2'b01};
    vecs[7] = '{4'b1111, 2'b10, 5'b00001, 2'b10};
    vecs[8] = '{4'b0011, 2'b10, 5'b01000, 2'b10};

    // Reset state, checked while reset is held and for 20 idle cycles after.
    repeat (3) @(negedge clk);
    chk1("in_reset", 5'b00001, 2'b00, 2'b00);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk1("idle", 5'b00001, 2'b00, 2'b00);
    end

    // Left held from edge 1: visible at edge 7, not edge 6.
    dir_l = 4'b1110;
    repeat (6) @(negedge clk);
    chk1("left_e6", 5'b00001, 2'b00, 2'b00);
    @(negedge clk);
    chk1("left_e7", 5'b00010, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    dir_l = 4'hF;
    repeat (6) @(negedge clk);
    chk1("rel_e6", 5'b00010, 2'b00, 2'b00);
    @(negedge clk);
    chk1("rel_e7", 5'b00001, 2'b00, 2'b00);
    settle(4);

    // 3-cycle glitch on right is rejected.
    dir_l = 4'b1101;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) dir_l = 4'hF;
      chk1("glitch3", 5'b00001, 2'b00, 2'b00);
    end

    // 4-cycle pulse is accepted, shown for 4 cycles, then released.
    dir_l = 4'b1101;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 4) dir_l = 4'hF;
      chk1("pulse4", (k >= 7 && k <= 10) ? 5'b00100 : 5'b00001, 2'b00, 2'b00);
    end
    settle(4);

    // Attack held for 50 cycles: level from edge 7, single press pulse at 7.
    btn[BTN_ATTACK] = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chk1("attack", 5'b00001, (k >= 7) ? 2'b01 : 2'b00, (k == 7) ? 2'b01 : 2'b00);
    end
    settle(12);

    // Table of steady-state vectors through the scoreboard.
    for (int v = 0; v < 9; v++) begin
      dir_l = vecs[v].dir_l;
      btn   = vecs[v].btn;
      e.dir = vecs[v].exp_dir;
      e.lvl = vecs[v].exp_lvl;
      e.prs = 2'b00;
      sb.push_back(e);
      repeat (10) @(negedge clk);
      e = sb.pop_front();
      chk_outs($sformatf("vec%0d", v), dir_onehot, btn_level, btn_press, led, e);
    end

    // Reset mid-count: outputs clear at once, and the held inputs must
    // pass the full window again after release.
    dir_l = 4'b1110;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk1("async_rst", 5'b00001, 2'b00, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk1("post_rst_e6", 5'b00001, 2'b00, 2'b00);
    @(negedge clk);
    chk1("post_rst_e7", 5'b00010, 2'b10, 2'b10);
    @(negedge clk);
    chk1("post_rst_e8", 5'b00010, 2'b10, 2'b00);
    settle(12);

    // Random stimulus on the DEBOUNCE_CYCLES=1, SYNC_STAGES=3 instance.
    // Every input value is accepted, so outputs equal the encoded inputs
    // delayed by 5 edges.
    prev_lvl = 2'b00;
    for (int k = 0; k < 5; k++) begin
      e.dir = 5'b00001; e.lvl = 2'b00; e.prs = 2'b00;
      sb2.push_back(e);
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      e = sb2.pop_front();
      chk_outs("rand", dir2_onehot, btn2_level, btn2_press, led2, e);
      if ($urandom_range(0, 2) == 0) dir2_l = 4'($urandom);
      if ($urandom_range(0, 2) == 0) btn2   = 2'($urandom);
      e.dir = encode(dir2_l);
      e.lvl = btn2;
      e.prs = btn2 & ~prev_lvl;
      prev_lvl = btn2;
      sb2.push_back(e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_controller_debounced
`default_nettype wire
